// File: rtl/cpu_ctrl.sv
// Multi-cycle accumulator CPU sequencer: FETCH/DECODE/EXEC/MEM control with
// a bounded memory-handshake wait, sticky error flags and a terminal HALT.
module cpu_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_en,
    output logic       acc_en,
    output logic       pc_sel,
    output logic       addr_sel,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [2:0] alu_op,
    output logic [2:0] state,
    output logic       busy,
    output logic       halted,
    output logic       err_ill,
    output logic       err_tmo
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2,
                           OP_ADD = 4'h3, OP_SUB = 4'h4, OP_AND = 4'h5,
                           OP_JMP = 4'h6, OP_JZ  = 4'h7, OP_HLT = 4'hF;
    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t     cur;
    logic [7:0] cnt;

    assign state = cur;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cur     <= S_IDLE;
            cnt     <= '0;
            err_ill <= 1'b0;
            err_tmo <= 1'b0;
        end else begin
            case (cur)
                S_IDLE: if (run) begin
                    cur <= S_FETCH;
                    cnt <= '0;
                end
                // FETCH and MEM share the wait/timeout handling; completion wins over timeout
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        cur <= (cur == S_FETCH) ? S_DECODE : S_FETCH;
                        cnt <= '0;
                    end else if (cnt == TMO) begin
                        err_tmo <= 1'b1;
                        cur     <= S_HALT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    cnt <= '0;
                    case (opcode)
                        OP_NOP:                                 cur <= S_FETCH;
                        OP_LDA, OP_STA:                         cur <= S_MEM;
                        OP_ADD, OP_SUB, OP_AND, OP_JMP, OP_JZ:  cur <= S_EXEC;
                        OP_HLT:                                 cur <= S_HALT;
                        default: begin
                            err_ill <= 1'b1;
                            cur     <= S_FETCH;
                        end
                    endcase
                end
                S_EXEC: begin
                    cur <= S_FETCH;
                    cnt <= '0;
                end
                S_HALT: cur <= S_HALT;
                default: cur <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_en    = 1'b0;
        ir_en    = 1'b0;
        acc_en   = 1'b0;
        pc_sel   = 1'b0;
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        alu_op   = 3'b000;
        busy     = (cur == S_FETCH) || (cur == S_DECODE) || (cur == S_EXEC) || (cur == S_MEM);
        halted   = (cur == S_HALT);
        case (cur)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_en = 1'b1;
                    pc_en = 1'b1;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_ADD: begin acc_en = 1'b1; alu_op = 3'b001; end
                    OP_SUB: begin acc_en = 1'b1; alu_op = 3'b010; end
                    OP_AND: begin acc_en = 1'b1; alu_op = 3'b011; end
                    OP_JMP: begin pc_en = 1'b1;  pc_sel = 1'b1;   end
                    OP_JZ:  begin pc_en = zero;  pc_sel = 1'b1;   end
                    default: ;
                endcase
            end
            // Anything other than STA in MEM is treated as a read so the strobes stay exclusive
            S_MEM: begin
                addr_sel = 1'b1;
                if (opcode == OP_STA) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                    acc_en = mem_ready;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed and randomized check of cpu_ctrl against an instruction-level
// reference model of the sequencer.
module tb_cpu_ctrl;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, ir_en, acc_en, pc_sel, addr_sel, mem_rd, mem_wr;
    logic [2:0] alu_op, state;
    logic       busy, halted, err_ill, err_tmo;

    int vectors = 0;
    int miscompares = 0;

    // reference model: phase name as an integer, cycles waited, sticky errors
    int m_st = 0;
    int m_wait = 0;
    bit m_ill = 0;
    bit m_tmo = 0;

    cpu_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .clr(clr), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .ir_en(ir_en), .acc_en(acc_en),
        .pc_sel(pc_sel), .addr_sel(addr_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .alu_op(alu_op), .state(state), .busy(busy), .halted(halted),
        .err_ill(err_ill), .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model_out();
        logic p, i, a, ps, as, rd, wr;
        logic [2:0] alu;
        p = 0; i = 0; a = 0; ps = 0; as = 0; rd = 0; wr = 0; alu = 0;
        if (m_st == 1) begin
            rd = 1;
            p = mem_ready;
            i = mem_ready;
        end else if (m_st == 3) begin
            if (opcode >= 3 && opcode <= 5) begin
                a = 1;
                alu = 3'(opcode - 4'd2);
            end else if (opcode == 6) begin
                p = 1; ps = 1;
            end else if (opcode == 7) begin
                p = zero; ps = 1;
            end
        end else if (m_st == 4) begin
            as = 1;
            if (opcode == 2) wr = 1;
            else begin rd = 1; a = mem_ready; end
        end
        return {3'(m_st), p, i, a, ps, as, rd, wr, alu,
                logic'(m_st >= 1 && m_st <= 4), logic'(m_st == 6), m_ill, m_tmo};
    endfunction

    task automatic model_clock();
        case (m_st)
            0: if (run) begin m_st = 1; m_wait = 0; end
            1, 4: begin
                if (mem_ready) begin
                    m_st = (m_st == 1) ? 2 : 1;
                    m_wait = 0;
                end else if (m_wait == 15) begin
                    m_tmo = 1; m_st = 6;
                end else m_wait++;
            end
            2: begin
                m_wait = 0;
                if (opcode == 0) m_st = 1;
                else if (opcode <= 2) m_st = 4;
                else if (opcode <= 7) m_st = 3;
                else if (opcode == 15) m_st = 6;
                else begin m_ill = 1; m_st = 1; end
            end
            3: begin m_st = 1; m_wait = 0; end
            default: ;
        endcase
    endtask

    task automatic check(input string tag);
        logic [16:0] obs, exp;
        exp = model_out();
        obs = {state, pc_en, ir_en, acc_en, pc_sel, addr_sel, mem_rd, mem_wr,
               alu_op, busy, halted, err_ill, err_tmo};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h (model state %0d)", tag, obs, exp, m_st);
        end
    endtask

    task automatic chk_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, check mid-cycle, model follows the posedge
    task automatic step(input string tag, input logic r, input logic [3:0] op,
                        input logic z, input logic mr);
        run = r; opcode = op; zero = z; mem_ready = mr;
        #1 check(tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    // clr arrives between clock edges; outputs must drop without a clock
    task automatic do_clr(input string tag);
        #2 clr = 1'b1;
        m_st = 0; m_wait = 0; m_ill = 0; m_tmo = 0;
        #1 check(tag);
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        #1 check("reset");
        chk_val("reset_state", 8'(state), 8'd0);
        clr = 1'b0;
        @(negedge clk);

        // ADD then HLT
        step("add_idle",   1, 4'h3, 0, 1);
        step("add_fetch",  1, 4'h3, 0, 1);
        step("add_decode", 1, 4'h3, 0, 1);
        step("add_exec",   1, 4'h3, 0, 1);
        step("hlt_fetch",  0, 4'hF, 0, 1);
        step("hlt_decode", 0, 4'hF, 0, 1);
        step("halt",       1, 4'hF, 0, 1);
        step("halt_stay",  1, 4'h3, 0, 1);
        chk_val("halt_state", 8'(state), 8'd6);
        chk_val("halted", 8'(halted), 8'd1);

        // LDA with three wait cycles in MEM
        do_clr("clr_lda");
        step("lda_idle",   1, 4'h1, 0, 1);
        step("lda_fetch",  0, 4'h1, 0, 1);
        step("lda_decode", 0, 4'h1, 0, 1);
        for (int k = 0; k < 3; k++) step("lda_mem_wait", 0, 4'h1, 0, 0);
        step("lda_mem_done", 0, 4'h1, 0, 1);
        chk_val("lda_back_fetch", 8'(state), 8'd1);

        // STA, then JZ with zero=0 and zero=1
        step("sta_fetch",  0, 4'h2, 0, 1);
        step("sta_decode", 0, 4'h2, 0, 1);
        step("sta_mem",    0, 4'h2, 0, 1);
        for (int zz = 0; zz < 2; zz++) begin
            step("jz_fetch",  0, 4'h7, 1'(zz), 1);
            step("jz_decode", 0, 4'h7, 1'(zz), 1);
            step("jz_exec",   0, 4'h7, 1'(zz), 1);
        end
        step("nop_fetch",  0, 4'h0, 0, 1);
        step("nop_decode", 0, 4'h0, 0, 1);

        // FETCH timeout
        do_clr("clr_tmo");
        step("tmo_idle", 1, 4'h0, 0, 0);
        for (int k = 0; k < 16; k++) step("tmo_fetch", 1, 4'h0, 0, 0);
        chk_val("tmo_state", 8'(state), 8'd6);
        chk_val("tmo_flag", 8'(err_tmo), 8'd1);
        for (int k = 0; k < 3; k++) step("tmo_halt", 1, 4'h1, 0, 1);

        // illegal opcode, then clr during a pending LDA
        do_clr("clr_ill");
        step("ill_idle",   1, 4'hA, 0, 1);
        step("ill_fetch",  0, 4'hA, 0, 1);
        step("ill_decode", 0, 4'hA, 0, 1);
        chk_val("ill_flag", 8'(err_ill), 8'd1);
        step("ill_refetch", 0, 4'h1, 0, 1);
        step("mid_decode",  0, 4'h1, 0, 1);
        step("mid_mem",     0, 4'h1, 0, 0);
        mem_ready = 1'b0;
        do_clr("clr_mid_mem");
        chk_val("clr_mem_rd", 8'(mem_rd), 8'd0);
        step("post_clr_idle", 0, 4'h1, 0, 1);
        chk_val("post_clr_state", 8'(state), 8'd0);

        // randomized sequences
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0 || (m_st == 6 && $urandom_range(0, 3) == 0))
                do_clr("rand_clr");
            else
                step("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
